// File: rtl/cheat_loader_if.sv
// ----------------------------------------------------------------------------
// cheat_loader_if
// Byte-download handshake between the ioctl download mux (master) and the
// cheat loader (slave).
//   dl_start : one-cycle pulse, a new cheat file begins
//   dl_end   : one-cycle pulse, the download is complete
//   dl_wr    : byte write strobe
//   dl_data  : download byte
//   dl_wait  : backpressure from the loader to the writer
// ----------------------------------------------------------------------------
interface cheat_loader_if;
    logic       dl_start;
    logic       dl_end;
    logic       dl_wr;
    logic [7:0] dl_data;
    logic       dl_wait;

    modport master (
        output dl_start,
        output dl_end,
        output dl_wr,
        output dl_data,
        input  dl_wait
    );

    modport slave (
        input  dl_start,
        input  dl_end,
        input  dl_wr,
        input  dl_data,
        output dl_wait
    );
endinterface

// File: rtl/cheat_loader.sv
// ----------------------------------------------------------------------------
// cheat_loader
// Turns the HPS cheat-file byte stream into 129-bit code words for the cheat
// engine. Each 16-byte record (flags, addr, compare, replace; 32-bit
// little-endian each) is assembled in place, then presented with a load
// strobe on code[128] surrounded by quiet cycles. The writer is throttled
// through dl_wait while a record is being issued; one byte of skid is
// absorbed by a hold register.
//
// Ports
//   clk, reset    : system clock, synchronous active-high reset
//   dl            : download handshake (slave modport)
//   codes_clear   : one-cycle pulse to the engine's cold reset on file start
//   code          : {strobe, flags, addr, compare, replace}
//   codes_loaded  : records issued since the last file start (saturating)
//   overflow      : sticky, a record was discarded past MAX_CODES
//   overrun       : sticky, a byte was dropped with the hold register full
//   busy          : high while not idle
// ----------------------------------------------------------------------------
module cheat_loader #(
    parameter int MAX_CODES  = 32,
    parameter int STROBE_LEN = 2
) (
    input  logic           clk,
    input  logic           reset,
    cheat_loader_if.slave  dl,
    output logic           codes_clear,
    output logic [128:0]   code,
    output logic [5:0]     codes_loaded,
    output logic           overflow,
    output logic           overrun,
    output logic           busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_STROBE  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    localparam logic [5:0] max_codes_c = 6'(MAX_CODES);
    localparam logic [3:0] last_cnt_c  = 4'(STROBE_LEN - 1);

    state_t         state_r;
    logic [3:0]     bidx_r;
    logic [127:0]   fields_r;
    logic           strobe_r;
    logic [3:0]     cnt_r;
    logic [5:0]     loaded_r;
    logic           overflow_r;
    logic           overrun_r;
    logic           hold_valid_r;
    logic [7:0]     hold_data_r;
    logic           end_seen_r;
    logic           clear_r;
    logic           wait_r;
    logic           busy_r;

    logic           take_s;
    logic [7:0]     byte_s;
    logic           last_s;
    logic           refill_s;
    logic           in_wait_s;

    // Bit position of stream byte idx inside code[127:0]. The top two bits of
    // idx select the field (flags sits highest), the low two bits select the
    // byte inside the little-endian field.
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        return {~idx[3:2], idx[1:0], 3'b000};
    endfunction

    // Byte source while collecting: a pending hold byte always goes first.
    always_comb begin
        take_s = 1'b0;
        byte_s = 8'h00;
        if (hold_valid_r) begin
            take_s = 1'b1;
            byte_s = hold_data_r;
        end else if (dl.dl_wr) begin
            take_s = 1'b1;
            byte_s = dl.dl_data;
        end else begin
            take_s = 1'b0;
            byte_s = 8'h00;
        end
    end

    // A write that arrives while the hold byte is being consumed refills it.
    assign refill_s  = hold_valid_r & dl.dl_wr;
    assign last_s    = take_s & (bidx_r == 4'd15);
    assign in_wait_s = (state_r == ST_SETTLE) | (state_r == ST_STROBE) |
                       (state_r == ST_GAP);

    // Main sequencer: file framing, byte assembly, strobe timing, backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bidx_r       <= 4'd0;
            fields_r     <= 128'd0;
            strobe_r     <= 1'b0;
            cnt_r        <= 4'd0;
            loaded_r     <= 6'd0;
            overflow_r   <= 1'b0;
            overrun_r    <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_data_r  <= 8'h00;
            end_seen_r   <= 1'b0;
            clear_r      <= 1'b0;
            wait_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else if (dl.dl_start) begin
            // New file, from IDLE or as an abort: the record fields are left
            // alone, everything that describes progress is cleared.
            state_r      <= ST_COLLECT;
            bidx_r       <= 4'd0;
            strobe_r     <= 1'b0;
            cnt_r        <= 4'd0;
            loaded_r     <= 6'd0;
            overflow_r   <= 1'b0;
            overrun_r    <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_data_r  <= 8'h00;
            end_seen_r   <= 1'b0;
            clear_r      <= 1'b1;
            wait_r       <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            clear_r <= 1'b0;

            // While a record is being issued, one byte may be parked; any
            // further byte is lost. dl_end is remembered until the gap ends.
            if (in_wait_s) begin
                if (dl.dl_wr) begin
                    if (hold_valid_r) begin
                        overrun_r <= 1'b1;
                    end else begin
                        hold_valid_r <= 1'b1;
                        hold_data_r  <= dl.dl_data;
                    end
                end
                if (dl.dl_end) begin
                    end_seen_r <= 1'b1;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    strobe_r   <= 1'b0;
                    end_seen_r <= 1'b0;
                    wait_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end

                ST_COLLECT: begin
                    busy_r <= 1'b1;
                    if (last_s && (loaded_r < max_codes_c)) begin
                        // Final byte of an issuable record; dl_end in the
                        // same cycle still lets the record go out.
                        fields_r[byte_lsb(bidx_r) +: 8] <= byte_s;
                        bidx_r       <= 4'd0;
                        hold_valid_r <= refill_s;
                        if (refill_s) begin
                            hold_data_r <= dl.dl_data;
                        end
                        end_seen_r   <= dl.dl_end;
                        state_r      <= ST_SETTLE;
                        wait_r       <= 1'b1;
                    end else if (dl.dl_end) begin
                        // Partial record and any parked byte are dropped.
                        overflow_r   <= overflow_r | last_s;
                        bidx_r       <= 4'd0;
                        hold_valid_r <= 1'b0;
                        end_seen_r   <= 1'b0;
                        state_r      <= ST_IDLE;
                        wait_r       <= 1'b0;
                        busy_r       <= 1'b0;
                    end else if (take_s) begin
                        // bidx wraps to 0 after the 16th byte of a record
                        // that is discarded for exceeding MAX_CODES.
                        fields_r[byte_lsb(bidx_r) +: 8] <= byte_s;
                        bidx_r       <= bidx_r + 4'd1;
                        overflow_r   <= overflow_r | last_s;
                        hold_valid_r <= refill_s;
                        if (refill_s) begin
                            hold_data_r <= dl.dl_data;
                        end
                        wait_r       <= refill_s;
                    end else begin
                        wait_r <= 1'b0;
                    end
                end

                ST_SETTLE: begin
                    state_r  <= ST_STROBE;
                    strobe_r <= 1'b1;
                    cnt_r    <= 4'd0;
                    wait_r   <= 1'b1;
                    busy_r   <= 1'b1;
                end

                ST_STROBE: begin
                    wait_r <= 1'b1;
                    busy_r <= 1'b1;
                    if (cnt_r == last_cnt_c) begin
                        strobe_r <= 1'b0;
                        cnt_r    <= 4'd0;
                        state_r  <= ST_GAP;
                        if (loaded_r < max_codes_c) begin
                            loaded_r <= loaded_r + 6'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end

                ST_GAP: begin
                    if (cnt_r == last_cnt_c) begin
                        cnt_r <= 4'd0;
                        if (end_seen_r || dl.dl_end) begin
                            state_r      <= ST_IDLE;
                            hold_valid_r <= 1'b0;
                            end_seen_r   <= 1'b0;
                            wait_r       <= 1'b0;
                            busy_r       <= 1'b0;
                        end else begin
                            // Keep throttling if a byte is parked for the
                            // next record.
                            state_r <= ST_COLLECT;
                            bidx_r  <= 4'd0;
                            wait_r  <= hold_valid_r | dl.dl_wr;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r  <= cnt_r + 4'd1;
                        wait_r <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end

                default: begin
                    state_r      <= ST_IDLE;
                    strobe_r     <= 1'b0;
                    hold_valid_r <= 1'b0;
                    end_seen_r   <= 1'b0;
                    wait_r       <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign dl.dl_wait   = wait_r;
    assign codes_clear  = clear_r;
    assign code         = {strobe_r, fields_r};
    assign codes_loaded = loaded_r;
    assign overflow     = overflow_r;
    assign overrun      = overrun_r;
    assign busy         = busy_r;

endmodule
